// File: rtl/alu_op_sequencer_if.sv
// Request/response and ALU-drive signals between the control unit, the sequencer and the ALU.
// The sequencer is the master: it takes requests and ALU results and drives the ALU and the result.
interface alu_op_sequencer_if #(
    parameter int WIDTH   = 64,
    parameter int SH_BITS = 6
);
    logic               start;
    logic [4:0]         opcode;
    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;
    logic [SH_BITS-1:0] shamt;
    logic [WIDTH-1:0]   alu_result;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [4:0]         alu_ctrl;
    logic               alu_enable;
    logic [WIDTH-1:0]   result;
    logic               done;
    logic               busy;
    logic               err;

    modport master (
        input  start, opcode, a_in, b_in, shamt, alu_result,
        output alu_a, alu_b, alu_ctrl, alu_enable, result, done, busy, err
    );

    modport slave (
        output start, opcode, a_in, b_in, shamt, alu_result,
        input  alu_a, alu_b, alu_ctrl, alu_enable, result, done, busy, err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Drives one ALU operation per request; multi-bit shifts/rotates run as repeated 1-bit passes
// with the ALU result fed back as operand A. Every output comes straight from a register.
module alu_op_sequencer #(
    parameter int WIDTH   = 64,
    parameter int SH_BITS = 6
) (
    input  logic                clk,
    input  logic                clr,
    alu_op_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FIN
    } state_t;

    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_LAST = 5'd11;

    state_t             state_q, state_d;
    logic [4:0]         opcode_q, opcode_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [SH_BITS-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic               err_pend_q, err_pend_d;

    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [4:0]         alu_ctrl_q, alu_ctrl_d;
    logic               alu_enable_q, alu_enable_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    function automatic logic is_shift(input logic [4:0] op);
        return (op >= 5'd4) && (op <= 5'd7);
    endfunction

    // ALU drive values are computed for the state being entered, so alu_enable is high
    // exactly during ISSUE and the ALU result is ready while the sequencer sits in WAIT.
    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        b_d          = b_q;
        cnt_d        = cnt_q;
        work_d       = work_q;
        err_pend_d   = err_pend_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctrl_d   = alu_ctrl_q;
        alu_enable_d = 1'b0;
        result_d     = result_q;
        done_d       = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    opcode_d   = bus.opcode;
                    b_d        = bus.b_in;
                    cnt_d      = bus.shamt;
                    work_d     = bus.a_in;
                    err_pend_d = 1'b0;
                    if ((bus.opcode > OP_LAST) ||
                        ((bus.opcode == OP_DIV) && (bus.b_in == '0))) begin
                        err_pend_d = 1'b1;
                        state_d    = S_FIN;
                    end else if (is_shift(bus.opcode) && (bus.shamt == '0)) begin
                        state_d = S_FIN;
                    end else begin
                        alu_a_d      = bus.a_in;
                        alu_b_d      = bus.b_in;
                        alu_ctrl_d   = bus.opcode;
                        alu_enable_d = 1'b1;
                        state_d      = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                work_d = bus.alu_result;
                if (is_shift(opcode_q) && (cnt_q > SH_BITS'(1))) begin
                    cnt_d        = cnt_q - SH_BITS'(1);
                    alu_a_d      = bus.alu_result;
                    alu_b_d      = b_q;
                    alu_ctrl_d   = opcode_q;
                    alu_enable_d = 1'b1;
                    state_d      = S_ISSUE;
                end else begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                result_d = err_pend_q ? '0 : work_q;
                done_d   = 1'b1;
                err_d    = err_pend_q;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= S_IDLE;
            opcode_q     <= '0;
            b_q          <= '0;
            cnt_q        <= '0;
            work_q       <= '0;
            err_pend_q   <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= '0;
            alu_enable_q <= 1'b0;
            result_q     <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            b_q          <= b_d;
            cnt_q        <= cnt_d;
            work_q       <= work_d;
            err_pend_q   <= err_pend_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            alu_enable_q <= alu_enable_d;
            result_q     <= result_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_ctrl   = alu_ctrl_q;
    assign bus.alu_enable = alu_enable_q;
    assign bus.result     = result_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a 1-bit-shift ALU stand-in plus a whole-operation reference model.
module tb_alu_op_sequencer;

    localparam int W = 64;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_op_sequencer_if #(.WIDTH(W), .SH_BITS(6)) bus ();

    alu_op_sequencer #(.WIDTH(W), .SH_BITS(6)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.master)
    );

    // ALU stand-in: registered output, shifts/rotates move a single bit per pass
    function automatic logic [W-1:0] alu_f(input logic [4:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        case (c)
            5'd0:    return a + b;
            5'd1:    return a - b;
            5'd2:    return a * b;
            5'd3:    return (b == '0) ? '0 : a / b;
            5'd4:    return a >> 1;
            5'd5:    return a << 1;
            5'd6:    return {a[0], a[W-1:1]};
            5'd7:    return {a[W-2:0], a[W-1]};
            5'd8:    return a & b;
            5'd9:    return a | b;
            5'd10:   return -a;
            5'd11:   return ~a;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (clr) bus.alu_result <= '0;
        else if (bus.alu_enable) bus.alu_result <= alu_f(bus.alu_ctrl, bus.alu_a, bus.alu_b);
    end

    typedef struct {
        int           ed;
        logic [4:0]   ctrl;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pulse_t;
    pulse_t pq[$];

    always @(negedge clk) begin
        if (bus.alu_enable) pq.push_back('{cyc, bus.alu_ctrl, bus.alu_a, bus.alu_b});
    end

    // Whole-request expectation from the operation rules: final value, error, latency, passes
    function automatic void ref_model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                      input int n, output logic [W-1:0] res, output logic e,
                                      output int lat, output int pulses);
        e = 1'b0; res = '0; lat = 3; pulses = 1;
        if (op > 5'd11 || (op == 5'd3 && b == '0)) begin
            e = 1'b1; lat = 1; pulses = 0;
        end else if (op >= 5'd4 && op <= 5'd7) begin
            if (n == 0) begin
                res = a; lat = 1; pulses = 0;
            end else begin
                lat = 1 + 2 * n; pulses = n;
                case (op)
                    5'd4:    res = a >> n;
                    5'd5:    res = a << n;
                    5'd6:    res = (a >> n) | (a << (W - n));
                    default: res = (a << n) | (a >> (W - n));
                endcase
            end
        end else begin
            case (op)
                5'd0:    res = a + b;
                5'd1:    res = a - b;
                5'd2:    res = a * b;
                5'd3:    res = a / b;
                5'd8:    res = a & b;
                5'd9:    res = a | b;
                5'd10:   res = 0 - a;
                default: res = ~a;
            endcase
        end
    endfunction

    task automatic run_req(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [5:0] n, input int inject,
                           output int t_edge, output int p0, output int lat, output logic [W-1:0] res,
                           output logic e, output logic busy_seen, output logic [W-1:0] mid_res,
                           output logic timed_out);
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = op; bus.a_in = a; bus.b_in = b; bus.shamt = n;
        t_edge = cyc + 1; p0 = pq.size(); mid_res = bus.result;
        @(negedge clk);
        bus.start = 1'b0;
        bus.opcode = 5'($urandom); bus.a_in = {$urandom, $urandom};
        bus.b_in = {$urandom, $urandom}; bus.shamt = 6'($urandom);
        busy_seen = bus.busy;
        timed_out = 1'b1; lat = -1; res = '0; e = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (bus.done) begin
                timed_out = 1'b0; lat = cyc - t_edge; res = bus.result; e = bus.err;
                break;
            end
            if (inject > 0 && k == inject) begin
                bus.start = 1'b1; mid_res = bus.result;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    int t_edge, p0, lat, elat, epul, np;
    logic [W-1:0] res, eres, mid_res;
    logic e, ee, busy_seen, tmo;

    task automatic test_reset();
        #2;
        checks++; if (bus.alu_enable !== 1'b0) $display("FAIL reset_alu_enable got %b want 0", bus.alu_enable); else passed++;
        checks++; if (bus.alu_a !== '0 || bus.alu_b !== '0 || bus.alu_ctrl !== '0) $display("FAIL reset_alu_bus got a=%h b=%h c=%h want 0", bus.alu_a, bus.alu_b, bus.alu_ctrl); else passed++;
        checks++; if (bus.result !== '0) $display("FAIL reset_result got %h want 0", bus.result); else passed++;
        checks++; if ({bus.done, bus.busy, bus.err} !== 3'b000) $display("FAIL reset_flags got %b want 000", {bus.done, bus.busy, bus.err}); else passed++;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        $display("reset released at cycle %0d", cyc);
    endtask

    task automatic test_add();
        run_req(5'd0, 64'd5, 64'd7, 6'd0, 0, t_edge, p0, lat, res, e, busy_seen, mid_res, tmo);
        np = pq.size() - p0;
        $display("add: lat=%0d result=%0d err=%b pulses=%0d", lat, res, e, np);
        checks++; if (tmo) $display("FAIL add_timeout got no done want done"); else passed++;
        checks++; if (lat != 3) $display("FAIL add_latency got %0d want 3", lat); else passed++;
        checks++; if (res !== 64'd12 || e !== 1'b0) $display("FAIL add_result got %0d err=%b want 12 err=0", res, e); else passed++;
        checks++; if (np != 1) $display("FAIL add_pulses got %0d want 1", np); else passed++;
        if (pq.size() > p0) begin
            checks++; if (pq[p0].ed != t_edge || pq[p0].ctrl !== 5'd0 || pq[p0].a !== 64'd5 || pq[p0].b !== 64'd7)
                $display("FAIL add_issue got ed=%0d c=%0d a=%0d b=%0d want ed=%0d c=0 a=5 b=7", pq[p0].ed, pq[p0].ctrl, pq[p0].a, pq[p0].b, t_edge);
            else passed++;
        end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0 || bus.result !== 64'd12) $display("FAIL add_after got done=%b result=%0d want done=0 result=12", bus.done, bus.result); else passed++;
    endtask

    task automatic test_shift();
        run_req(5'd5, 64'd1, 64'd0, 6'd4, 0, t_edge, p0, lat, res, e, busy_seen, mid_res, tmo);
        np = pq.size() - p0;
        $display("shl4: lat=%0d result=%0d pulses=%0d", lat, res, np);
        checks++; if (tmo || lat != 9) $display("FAIL shl_latency got %0d timeout=%b want 9", lat, tmo); else passed++;
        checks++; if (res !== 64'd16 || e !== 1'b0) $display("FAIL shl_result got %0d err=%b want 16 err=0", res, e); else passed++;
        checks++; if (np != 4) $display("FAIL shl_pulses got %0d want 4", np); else passed++;
        checks++; if (busy_seen !== 1'b1) $display("FAIL shl_busy got %b want 1", busy_seen); else passed++;
        for (int i = 0; i < 4; i++) begin
            if (p0 + i < pq.size()) begin
                checks++;
                if (pq[p0+i].ed != t_edge + 2 * i || pq[p0+i].a !== (64'd1 << i) || pq[p0+i].ctrl !== 5'd5)
                    $display("FAIL shl_pass%0d got ed=%0d a=%0d c=%0d want ed=%0d a=%0d c=5", i, pq[p0+i].ed, pq[p0+i].a, pq[p0+i].ctrl, t_edge + 2 * i, 64'd1 << i);
                else passed++;
            end
        end
        // longest iteration count
        run_req(5'd7, 64'h8000_0000_0000_0001, 64'd0, 6'd63, 0, t_edge, p0, lat, res, e, busy_seen, mid_res, tmo);
        ref_model(5'd7, 64'h8000_0000_0000_0001, 64'd0, 63, eres, ee, elat, epul);
        np = pq.size() - p0;
        $display("rol63: lat=%0d result=%h pulses=%0d", lat, res, np);
        checks++; if (tmo || lat != elat || np != epul) $display("FAIL rol63_timing got lat=%0d pulses=%0d want lat=%0d pulses=%0d", lat, np, elat, epul); else passed++;
        checks++; if (res !== eres) $display("FAIL rol63_result got %h want %h", res, eres); else passed++;
    endtask

    task automatic test_errors();
        run_req(5'd3, 64'd99, 64'd0, 6'd0, 0, t_edge, p0, lat, res, e, busy_seen, mid_res, tmo);
        np = pq.size() - p0;
        $display("div0: lat=%0d result=%0d err=%b pulses=%0d", lat, res, e, np);
        checks++; if (tmo || lat != 1) $display("FAIL div0_latency got %0d want 1", lat); else passed++;
        checks++; if (res !== '0 || e !== 1'b1 || np != 0) $display("FAIL div0_outcome got result=%0d err=%b pulses=%0d want 0 1 0", res, e, np); else passed++;
        @(negedge clk);
        checks++; if (bus.err !== 1'b0 || bus.done !== 1'b0) $display("FAIL div0_clear got err=%b done=%b want 0 0", bus.err, bus.done); else passed++;
        run_req(5'd12, 64'd3, 64'd4, 6'd0, 0, t_edge, p0, lat, res, e, busy_seen, mid_res, tmo);
        np = pq.size() - p0;
        $display("op12: lat=%0d result=%0d err=%b pulses=%0d", lat, res, e, np);
        checks++; if (tmo || lat != 1) $display("FAIL op12_latency got %0d want 1", lat); else passed++;
        checks++; if (res !== '0 || e !== 1'b1 || np != 0) $display("FAIL op12_outcome got result=%0d err=%b pulses=%0d want 0 1 0", res, e, np); else passed++;
    endtask

    task automatic test_zero_shift_busy();
        run_req(5'd6, 64'hDEAD_BEEF_0123_4567, 64'd0, 6'd0, 0, t_edge, p0, lat, res, e, busy_seen, mid_res, tmo);
        $display("ror0: lat=%0d result=%h err=%b", lat, res, e);
        checks++; if (tmo || lat != 1) $display("FAIL ror0_latency got %0d want 1", lat); else passed++;
        checks++; if (res !== 64'hDEAD_BEEF_0123_4567 || e !== 1'b0) $display("FAIL ror0_result got %h err=%b want deadbeef01234567 err=0", res, e); else passed++;
        run_req(5'd4, 64'hF000, 64'd0, 6'd5, 2, t_edge, p0, lat, res, e, busy_seen, mid_res, tmo);
        np = pq.size() - p0;
        $display("shr5 with stray start: lat=%0d result=%h pulses=%0d mid=%h", lat, res, np, mid_res);
        checks++; if (mid_res !== 64'hDEAD_BEEF_0123_4567) $display("FAIL busy_hold got %h want deadbeef01234567", mid_res); else passed++;
        checks++; if (tmo || lat != 11 || np != 5 || res !== 64'h0780) $display("FAIL busy_ignore got lat=%0d pulses=%0d result=%h want 11 5 780", lat, np, res); else passed++;
        np = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done || bus.busy) np++;
        end
        checks++; if (np != 0) $display("FAIL busy_noqueue got %0d active cycles want 0", np); else passed++;
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = 5'd5; bus.a_in = 64'd3; bus.shamt = 6'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        #1;
        $display("abort: result=%h busy=%b enable=%b", bus.result, bus.busy, bus.alu_enable);
        checks++; if (bus.result !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) $display("FAIL abort_flags got result=%h busy=%b done=%b err=%b want 0", bus.result, bus.busy, bus.done, bus.err); else passed++;
        checks++; if (bus.alu_enable !== 1'b0 || bus.alu_a !== '0 || bus.alu_ctrl !== '0) $display("FAIL abort_alu got en=%b a=%h c=%0d want 0", bus.alu_enable, bus.alu_a, bus.alu_ctrl); else passed++;
        @(negedge clk);
        clr = 1'b0;
        np = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) np++;
        end
        checks++; if (np != 0) $display("FAIL abort_nodone got %0d done cycles want 0", np); else passed++;
        run_req(5'd9, 64'hF0, 64'h0F, 6'd0, 0, t_edge, p0, lat, res, e, busy_seen, mid_res, tmo);
        $display("after abort: lat=%0d result=%h", lat, res);
        checks++; if (tmo || lat != 3 || res !== 64'hFF || e !== 1'b0) $display("FAIL abort_recover got lat=%0d result=%h err=%b want 3 ff 0", lat, res, e); else passed++;
    endtask

    task automatic test_random();
        logic [4:0]   op;
        logic [W-1:0] a, b;
        int           n;
        for (int i = 0; i < 30; i++) begin
            op = 5'($urandom_range(0, 13));
            a  = {$urandom, $urandom};
            b  = ($urandom_range(0, 5) == 0) ? '0 : {$urandom, $urandom};
            n  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
            ref_model(op, a, b, n, eres, ee, elat, epul);
            run_req(op, a, b, 6'(n), 0, t_edge, p0, lat, res, e, busy_seen, mid_res, tmo);
            np = pq.size() - p0;
            $display("rand %0d: op=%0d n=%0d lat=%0d result=%h err=%b pulses=%0d", i, op, n, lat, res, e, np);
            checks++;
            if (tmo || lat != elat || res !== eres || e !== ee || np != epul)
                $display("FAIL rand%0d got lat=%0d res=%h err=%b pulses=%0d want lat=%0d res=%h err=%b pulses=%0d", i, lat, res, e, np, elat, eres, ee, epul);
            else passed++;
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.opcode = '0; bus.a_in = '0; bus.b_in = '0; bus.shamt = '0;
        test_reset();
        test_add();
        test_shift();
        test_errors();
        test_zero_shift_busy();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
